// File: rtl/multi_pop_queue.sv
// Circular queue with a single-entry push port and a 0..MAX_POP pop port.
// The head MAX_POP entries are presented concatenated, oldest in the MSBs.
module multi_pop_queue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 5,
  parameter int MAX_POP = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(MAX_POP + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PW-1:0]             pop_req,
  output logic [PW-1:0]             pop_grant,
  output logic [MAX_POP*DATA_W-1:0] out_data,
  output logic [PW-1:0]             out_avail,
  output logic [CNT_W-1:0]          count,
  output logic                      empty,
  output logic                      full,
  input  logic                      flush,
  output logic                      err_ovf,
  output logic                      err_udf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  req_clamp;
  logic [CNT_W-1:0]  grant_c;
  logic              underflow;
  logic              push_acc;

  // Pointer advance with explicit compare, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input logic [CNT_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {{(CNT_W + 1 - PTR_W){1'b0}}, ptr} + {1'b0, inc};
    if (sum >= (CNT_W + 1)'(DEPTH)) begin
      sum = sum - (CNT_W + 1)'(DEPTH);
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == {CNT_W{1'b0}});
  assign push_acc  = in_valid && in_ready && !flush;
  assign pop_grant = PW'(grant_c);

  // Grant: request clamped to MAX_POP, then to the registered occupancy.
  always_comb begin
    req_clamp = CNT_W'(pop_req);
    underflow = 1'b0;
    if (req_clamp > CNT_W'(MAX_POP)) begin
      req_clamp = CNT_W'(MAX_POP);
    end else begin
      req_clamp = req_clamp;
    end
    if (req_clamp > count) begin
      grant_c   = count;
      underflow = 1'b1;
    end else begin
      grant_c   = req_clamp;
    end
  end

  // Next storage contents: zero the popped slots, then write the pushed entry.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_next[j] = mem[j];
    end
    for (int k = 0; k < MAX_POP; k++) begin
      if (CNT_W'(k) < grant_c) begin
        mem_next[wrap_add(head, CNT_W'(k))] = {DATA_W{1'b0}};
      end else begin
        mem_next[0] = mem_next[0];
      end
    end
    if (push_acc) begin
      mem_next[tail] = in_data;
    end else begin
      mem_next[0] = mem_next[0];
    end
  end

  // Head view and number of valid slots in it.
  always_comb begin
    out_data = {(MAX_POP * DATA_W){1'b0}};
    for (int k = 0; k < MAX_POP; k++) begin
      if (CNT_W'(k) < count) begin
        out_data[(MAX_POP - k) * DATA_W - 1 -: DATA_W] = mem[wrap_add(head, CNT_W'(k))];
      end else begin
        out_data[(MAX_POP - k) * DATA_W - 1 -: DATA_W] = {DATA_W{1'b0}};
      end
    end
    if (count > CNT_W'(MAX_POP)) begin
      out_avail = PW'(MAX_POP);
    end else begin
      out_avail = PW'(count);
    end
  end

  // Storage, pointers and occupancy; a flush drops any concurrent push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= {DATA_W{1'b0}};
      end
    end else begin
      head  <= wrap_add(head, grant_c);
      tail  <= push_acc ? wrap_add(tail, CNT_W'(1)) : tail;
      count <= count + CNT_W'(push_acc) - grant_c;
      for (int j = 0; j < DEPTH; j++) begin
        mem[j] <= mem_next[j];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | (in_valid & ~in_ready);
      err_udf <= err_udf | underflow;
    end
  end

endmodule

// File: tb/tb_multi_pop_queue.sv
// Directed bench for multi_pop_queue (DATA_W=8, DEPTH=5, MAX_POP=2) against a
// queue-based reference model, plus hand-computed literal expectations.
module tb_multi_pop_queue;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 5;
  localparam int MAX_POP = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PW      = $clog2(MAX_POP + 1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [DATA_W-1:0]         in_data = 8'h00;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [PW-1:0]             pop_req = 2'd0;
  logic [PW-1:0]             pop_grant;
  logic [MAX_POP*DATA_W-1:0] out_data;
  logic [PW-1:0]             out_avail;
  logic [CNT_W-1:0]          count;
  logic                      empty;
  logic                      full;
  logic                      flush = 1'b0;
  logic                      err_ovf;
  logic                      err_udf;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  int         exp_grant = 0;
  bit         chk_en = 1'b0;
  int         grant_seen = 0;

  multi_pop_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_POP(MAX_POP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pop_req(pop_req), .pop_grant(pop_grant),
    .out_data(out_data), .out_avail(out_avail), .count(count),
    .empty(empty), .full(full), .flush(flush),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_req(input int r);
    return (r > MAX_POP) ? MAX_POP : r;
  endfunction

  // One clock cycle: drive inputs, let the checker sample mid-cycle, then
  // advance the model with the same inputs at the rising edge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                     input int p, input bit f);
    int sz;
    int g;
    rst = r; in_valid = v; in_data = d; pop_req = PW'(p); flush = f;
    sz = q.size();
    g  = clamp_req(p);
    exp_grant = (g < sz) ? g : sz;
    #1;
    grant_seen = int'(pop_grant);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (v && sz >= DEPTH) m_ovf = 1'b1;
      if (g > sz) m_udf = 1'b1;
      if (f) begin
        q.delete();
      end else begin
        for (int i = 0; i < exp_grant; i++) void'(q.pop_front());
        if (v && sz < DEPTH) q.push_back(d);
      end
    end
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] e_data;
      int          sz;
      sz = q.size();
      e_data = 16'h0000;
      for (int k = 0; k < MAX_POP; k++) begin
        if (k < sz) e_data[(MAX_POP - k) * 8 - 1 -: 8] = q[k];
      end
      check("count",     32'(count),     32'(sz));
      check("out_data",  32'(out_data),  32'(e_data));
      check("out_avail", 32'(out_avail), 32'((sz < MAX_POP) ? sz : MAX_POP));
      check("empty",     32'(empty),     32'(sz == 0));
      check("full",      32'(full),      32'(sz == DEPTH));
      check("in_ready",  32'(in_ready),  32'(sz < DEPTH));
      check("pop_grant", 32'(pop_grant), 32'(exp_grant));
      check("err_ovf",   32'(err_ovf),   32'(m_ovf));
      check("err_udf",   32'(err_udf),   32'(m_udf));
    end
  end

  initial begin
    // reset
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
    check("rst_count",    32'(count),     32'd0);
    check("rst_out_data", 32'(out_data),  32'h0000);
    check("rst_avail",    32'(out_avail), 32'd0);
    check("rst_empty",    32'(empty),     32'd1);
    check("rst_full",     32'(full),      32'd0);
    check("rst_in_ready", 32'(in_ready),  32'd1);

    // push three entries
    cyc(1'b0, 1'b1, 8'h11, 0, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 0, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 0, 1'b0);
    check("p3_count", 32'(count),     32'd3);
    check("p3_data",  32'(out_data),  32'h1122);
    check("p3_avail", 32'(out_avail), 32'd2);
    check("p3_empty", 32'(empty),     32'd0);

    // pop two
    cyc(1'b0, 1'b0, 8'h00, 2, 1'b0);
    check("pop2_grant", 32'(grant_seen), 32'd2);
    check("pop2_data",  32'(out_data),   32'h3300);
    check("pop2_avail", 32'(out_avail),  32'd1);
    check("pop2_count", 32'(count),      32'd1);

    // underflow with simultaneous push
    cyc(1'b0, 1'b1, 8'hAA, 2, 1'b0);
    check("udf_grant", 32'(grant_seen), 32'd1);
    check("udf_flag",  32'(err_udf),    32'd1);
    check("udf_count", 32'(count),      32'd1);
    check("udf_data",  32'(out_data),   32'hAA00);

    // fill, then push while full with a pop
    cyc(1'b1, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) cyc(1'b0, 1'b1, 8'(i), 0, 1'b0);
    check("fill_full",  32'(full),     32'd1);
    check("fill_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b1, 8'h66, 1, 1'b0);
    check("ovf_grant", 32'(grant_seen), 32'd1);
    check("ovf_flag",  32'(err_ovf),    32'd1);
    check("ovf_count", 32'(count),      32'd4);
    check("ovf_ready", 32'(in_ready),   32'd1);
    check("ovf_data",  32'(out_data),   32'h0203);

    // request above MAX_POP is clamped and is not an underflow
    cyc(1'b0, 1'b0, 8'h00, 3, 1'b0);
    check("clamp_grant", 32'(grant_seen), 32'd2);
    check("clamp_udf",   32'(err_udf),    32'd0);
    check("clamp_count", 32'(count),      32'd2);
    check("clamp_data",  32'(out_data),   32'h0405);

    // wrap-around traffic: mixed push-only, pop-only and push+pop cycles
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, (i % 3) != 2, 8'(8'h70 + i), i % 2, 1'b0);
    end

    // flush with a concurrent push
    cyc(1'b0, 1'b1, 8'h91, 0, 1'b0);
    cyc(1'b0, 1'b1, 8'h99, 0, 1'b1);
    check("flush_count", 32'(count),    32'd0);
    check("flush_data",  32'(out_data), 32'h0000);
    check("flush_empty", 32'(empty),    32'd1);
    check("flush_ovf",   32'(err_ovf),  32'd1);

    // post-flush traffic, then reset clears sticky flags
    cyc(1'b0, 1'b1, 8'h5A, 0, 1'b0);
    cyc(1'b0, 1'b1, 8'hA5, 1, 1'b0);
    check("post_data", 32'(out_data), 32'hA500);
    cyc(1'b1, 1'b1, 8'hEE, 1, 1'b1);
    check("rst2_ovf",   32'(err_ovf), 32'd0);
    check("rst2_udf",   32'(err_udf), 32'd0);
    check("rst2_count", 32'(count),   32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_pop_queue.md
Name: multi_pop_queue

Overview:
Parametrised circular byte/word queue with a single-entry push port and a variable-count pop port. Each cycle the consumer may remove 0..MAX_POP entries from the head. The first MAX_POP head entries are presented concatenated, oldest in the MSBs. It is the generalised successor of the fixed 5-entry, 1-or-2-pop queue used in the calculator datapath. It adds occupancy tracking, a push handshake, flush, and sticky error flags.

Parameters:
DATA_W, 8, width of one entry
DEPTH, 5, number of entries (any value >= 2, not required to be a power of two)
MAX_POP, 2, maximum entries removed per cycle (1 <= MAX_POP <= DEPTH)
(local) CNT_W = $clog2(DEPTH+1); PW = $clog2(MAX_POP+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_data  in  DATA_W  entry to push at tail
in_valid  in  1  push request
in_ready  out  1  queue can accept a push this cycle
pop_req  in  PW  number of head entries to remove this cycle
pop_grant  out  PW  entries actually removed this cycle
out_data  out  MAX_POP*DATA_W  head view; slot k at bits [(MAX_POP-k)*DATA_W-1 -: DATA_W]
out_avail  out  PW  number of valid slots in out_data, min(count, MAX_POP)
count  out  CNT_W  current occupancy
empty  out  1  count == 0
full  out  1  count == DEPTH
flush  in  1  discard all contents
err_ovf  out  1  sticky: push attempted while full
err_udf  out  1  sticky: pop_req > count

Behaviour:
- Storage: DEPTH registers plus head and tail pointers, each wrapping DEPTH-1 -> 0 with explicit compare, not a power-of-two mask; count is a register.
- Reset (rst=1 at edge): head=tail=count=0; all storage cleared to 0; err_ovf=err_udf=0. Consequently out_data=0, out_avail=0, empty=1, full=0, in_ready=1. Reset overrides flush, push and pop in the same cycle.
- in_ready = (count < DEPTH). It depends only on registered count; a pop in the same cycle does not raise it.
- Push accepted when in_valid && in_ready: in_data is written at tail, and tail advances by 1 at the edge.
- pop_grant = min(pop_req, count), combinational from registered count. head advances by pop_grant modulo DEPTH.
- A pushed entry is never poppable in its push cycle, because the grant is based on count before the push. Push and pop in the same cycle are independent: next count = count + push_acc - pop_grant. This is legal at full, where in_ready=0 and only the pop happens, and at empty, where only the push happens.
- Vacated storage slots are written to 0 on pop.
- out_data slot k = storage[(head+k) mod DEPTH] if k < count, else 0. It is combinational from registers, so the view updates one edge after a push or pop.
- Latency: a push at edge N is visible in out_data/count after edge N.
- flush=1 (no rst): head=tail=count=0 and storage cleared. A concurrent push is dropped. Error flags are not cleared.
- err_ovf sets when in_valid && !in_ready. err_udf sets when pop_req > count; the partial grant still executes. Both flags clear only on rst.
- pop_req values above MAX_POP cannot occur given the PW width only when MAX_POP+1 is a power of two. Otherwise the grant is additionally clamped to MAX_POP, and err_udf does not set for this case.

Test Plan:
- Reset then push 0x11,0x22,0x33 (DEPTH=5, MAX_POP=2) -> count=3, out_data=0x1122, out_avail=2, empty=0.
- From that state pop_req=2 -> pop_grant=2; next cycle out_data=0x3300, out_avail=1, count=1.
- Fill 5 entries, then in_valid=1 with pop_req=1 -> push dropped, err_ovf=1, count=4. Next cycle in_ready=1.
- Wrap-around: push 7 and pop 1 per cycle in an alternating pattern so tail passes index 4->0 -> data order is preserved and out_data always holds the oldest two entries.
- count=1 with pop_req=2 and a simultaneous push of 0xAA -> pop_grant=1, err_udf=1, next count=1, out_data=0xAA00.
- Mid-stream flush with push -> count=0, out_data=0, push lost, sticky flags retained. Then rst -> flags cleared.
